// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive cores.
//   - tx_state_t : 2-bit FSM state encoding (idle/start/data/stop)
//   - OVERSAMPLE : ticks per bit period (16x oversampling)
//   - DEFAULT_BAUDRATE / DEFAULT_CLK_FREQUENCY : board defaults
//   - calc_div() : clocks per oversampling tick, integer truncation
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int OVERSAMPLE            = 16;
  localparam int DEFAULT_BAUDRATE      = 9600;
  localparam int DEFAULT_CLK_FREQUENCY = 100000000;

  // Clocks between oversampling ticks. Truncating division matches the
  // receive core so both ends agree on the bit period.
  function automatic int calc_div(input int clk_frequency, input int baudrate);
    return clk_frequency / (baudrate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx_core_tick.sv
// tx_baudrate_tick_generator: modulo-DIV counter producing a 1-clk tick.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; counter to 0
//   clear  : synchronous restart of the count at 0 (used at frame acceptance)
//   tick   : high for one clk each time the count reaches DIV-1
// After a clear on edge E, the first tick is acted on at edge E+DIV.
module tx_baudrate_tick_generator
  import uart_pkg::*;
#(
  parameter int baudrate  = DEFAULT_BAUDRATE,
  parameter int frequency = DEFAULT_CLK_FREQUENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = calc_div(frequency, baudrate);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Decoded straight from the count flop; only feeds internal logic.
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Sends 1 start bit (0), NUMBER_OF_DATA_BITS
// data bits LSB first, then a stop period (1) of NUMBER_OF_STOP_BIT_TICKS ticks.
// One bit period = 16 oversampling ticks.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high; aborts any frame in flight
//   tx_start     : send request, accepted only while idle (no queueing)
//   data_in      : byte to send, captured on acceptance
//   tx           : serial line, idle high, driven from a flop
//   tx_busy      : high from acceptance until the frame-end edge
//   tx_done_tick : 1-clk pulse on the frame-end edge
// Handshake: a transfer happens on a rising edge where the core is idle and
// tx_start is high; tx_busy is the inverse of "ready" one cycle late, and
// tx_start is ignored whenever the core is not idle.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int NUMBER_OF_DATA_BITS      = 8,
  parameter int NUMBER_OF_STOP_BIT_TICKS = 16,
  parameter int BAUDRATE                 = DEFAULT_BAUDRATE,
  parameter int CLK_FREQUENCY            = DEFAULT_CLK_FREQUENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tx_start,
  input  logic [NUMBER_OF_DATA_BITS-1:0] data_in,
  output logic                           tx,
  output logic                           tx_busy,
  output logic                           tx_done_tick
);

  localparam int BIT_W = $clog2(NUMBER_OF_DATA_BITS);
  localparam logic [4:0]       OVS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]       STOP_LAST = 5'(NUMBER_OF_STOP_BIT_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUMBER_OF_DATA_BITS - 1);

  tx_state_t                    state_q, state_d;
  logic [4:0]                   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [NUMBER_OF_DATA_BITS-1:0] shift_q, shift_d;
  logic                         tx_q, tx_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         clear_div;
  logic                         tick;

  tx_baudrate_tick_generator #(
    .baudrate  (BAUDRATE),
    .frequency (CLK_FREQUENCY)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_div),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clear_div  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          // Restarting the divider here makes every bit exactly 16*DIV
          // clocks long, measured from the acceptance edge.
          shift_d    = data_in;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          clear_div  = 1'b1;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == OVS_LAST) begin
            tick_cnt_d = '0;
            tx_d       = shift_q[0];
            state_d    = ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == OVS_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end else begin
              // shift_q[0] is on the line now; shift_q[1] is the next LSB.
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_d      = shift_q[1];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            // Back in idle this same edge, so a request in the done cycle
            // is accepted on the next edge with no extra idle bit.
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

  localparam int DIV      = 10;
  localparam int BIT_CLKS = 16 * DIV;

  logic       clk;
  logic       reset;
  logic       tx_start, tx_start32;
  logic [7:0] data_in, data_in32;
  logic       tx, tx_busy, tx_done_tick;
  logic       tx32, tx_busy32, tx_done_tick32;

  logic       sel;
  logic       mon_tx, mon_busy, mon_done;

  int         checks = 0;
  int         errors = 0;
  int         n_done = 0;
  int         n_done32 = 0;
  int         base_done;

  logic [7:0] exp_q[$];

  uart_tx_core #(
    .NUMBER_OF_DATA_BITS      (8),
    .NUMBER_OF_STOP_BIT_TICKS (16),
    .BAUDRATE                 (10),
    .CLK_FREQUENCY            (1600)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .data_in      (data_in),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_tx_core #(
    .NUMBER_OF_DATA_BITS      (8),
    .NUMBER_OF_STOP_BIT_TICKS (32),
    .BAUDRATE                 (10),
    .CLK_FREQUENCY            (1600)
  ) dut32 (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start32),
    .data_in      (data_in32),
    .tx           (tx32),
    .tx_busy      (tx_busy32),
    .tx_done_tick (tx_done_tick32)
  );

  assign mon_tx   = sel ? tx32 : tx;
  assign mon_busy = sel ? tx_busy32 : tx_busy;
  assign mon_done = sel ? tx_done_tick32 : tx_done_tick;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done pulses are full-cycle wide, so sampling at the edge sees each once.
  always @(posedge clk) begin
    if (tx_done_tick)   n_done   <= n_done + 1;
    if (tx_done_tick32) n_done32 <= n_done32 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   32'(mon_tx),   32'd1);
    chk({tag, "_busy"}, 32'(mon_busy), 32'd0);
    chk({tag, "_done"}, 32'(mon_done), 32'd0);
  endtask

  // Drives a request so that acceptance happens on the next edge; returns
  // at the negedge just after that edge (frame offset k = 0).
  task automatic start_frame(input logic [7:0] d, input bit hold, input bit push);
    @(negedge clk);
    if (sel) begin
      tx_start32 = 1'b1;
      data_in32  = d;
    end else begin
      tx_start = 1'b1;
      data_in  = d;
    end
    if (push) exp_q.push_back(d);
    @(negedge clk);
    if (!hold) begin
      tx_start   = 1'b0;
      tx_start32 = 1'b0;
    end
  endtask

  // Called at k = 0; returns at the frame-end observation point. Checks line
  // levels at the first, middle and last clock of each bit, decodes the byte
  // from mid-bit samples like a receiver would, and compares against the
  // scoreboard. inject_k >= 0 pulses an (ignored) request with 8'hFF there.
  task automatic check_frame(input int stop_ticks, input int inject_k);
    logic [7:0] exp_byte;
    logic [7:0] rx_byte;
    logic [9:0] lvl;
    int         k_end;
    int         bit_i;
    int         off;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    exp_byte = exp_q[0];
    lvl      = {1'b1, exp_byte, 1'b0};
    k_end    = 9 * BIT_CLKS + stop_ticks * DIV;
    rx_byte  = 8'h00;
    for (int k = 0; k <= k_end; k++) begin
      if (k > 0) @(negedge clk);
      if (inject_k >= 0) begin
        if (k == inject_k) begin
          tx_start = 1'b1;
          data_in  = 8'hFF;
        end else if (k == inject_k + 1) begin
          tx_start = 1'b0;
        end
      end
      if (k < k_end) begin
        bit_i = (k < 9 * BIT_CLKS) ? k / BIT_CLKS : 9;
        off   = k - bit_i * BIT_CLKS;
        if (bit_i >= 1 && bit_i <= 8 && off == BIT_CLKS / 2)
          rx_byte = {mon_tx, rx_byte[7:1]};
        if (off == 0 || off == BIT_CLKS / 2 || k == k_end - 1 ||
            (bit_i < 9 && off == BIT_CLKS - 1)) begin
          chk("tx_level",      32'(mon_tx),   32'(lvl[bit_i]));
          chk("busy_in_frame", 32'(mon_busy), 32'd1);
          chk("done_in_frame", 32'(mon_done), 32'd0);
        end
      end
    end
    chk("done_at_end", 32'(mon_done), 32'd1);
    chk("busy_at_end", 32'(mon_busy), 32'd0);
    chk("tx_at_end",   32'(mon_tx),   32'd1);
    chk("rx_byte",     32'(rx_byte),  32'(exp_q.pop_front()));
  endtask

  initial begin
    reset      = 1'b1;
    tx_start   = 1'b0;
    tx_start32 = 1'b0;
    data_in    = 8'h00;
    data_in32  = 8'h00;
    sel        = 1'b0;

    // 1. reset for 3 clocks, then idle outputs hold for 500 clocks
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (50) @(negedge clk);
      chk_idle("idle_hold");
    end
    chk("idle_no_done", 32'(n_done), 32'd0);

    // 2. single frame 8'hA5
    start_frame(8'hA5, 1'b0, 1'b1);
    check_frame(16, -1);
    @(negedge clk);
    chk_idle("a5_after");
    chk("a5_done_count", 32'(n_done), 32'd1);
    repeat (20) @(negedge clk);

    // 3. same frame, request with 8'hFF mid-frame must be ignored
    start_frame(8'hA5, 1'b0, 1'b1);
    check_frame(16, 300);
    @(negedge clk);
    chk_idle("ignore_after");
    repeat (200) @(negedge clk);
    chk_idle("ignore_idle");
    chk("ignore_done_count", 32'(n_done), 32'd2);

    // 4. tx_start held: 8'h55 then 8'h0F back-to-back
    base_done = n_done;
    start_frame(8'h55, 1'b1, 1'b1);
    data_in = 8'h0F;
    exp_q.push_back(8'h0F);
    check_frame(16, -1);
    @(negedge clk);
    chk("b2b_start_tx",   32'(tx),           32'd0);
    chk("b2b_start_busy", 32'(tx_busy),      32'd1);
    chk("b2b_start_done", 32'(tx_done_tick), 32'd0);
    tx_start = 1'b0;
    check_frame(16, -1);
    @(negedge clk);
    chk_idle("b2b_after");
    chk("b2b_done_count", 32'(n_done - base_done), 32'd2);
    repeat (20) @(negedge clk);

    // 5. reset during data bit 3 aborts, then 8'h3C goes out cleanly
    base_done = n_done;
    start_frame(8'hC3, 1'b0, 1'b0);
    repeat (699) @(negedge clk);
    chk("abort_pre_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort_reset");
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk_idle("abort_idle");
    chk("abort_no_done", 32'(n_done - base_done), 32'd0);
    start_frame(8'h3C, 1'b0, 1'b1);
    check_frame(16, -1);
    @(negedge clk);
    chk_idle("recover_after");
    chk("recover_done_count", 32'(n_done - base_done), 32'd1);

    // 6. two stop bits (32 ticks), data 8'h00
    sel       = 1'b1;
    base_done = n_done;
    start_frame(8'h00, 1'b0, 1'b1);
    check_frame(32, -1);
    @(negedge clk);
    chk_idle("stop32_after");
    chk("stop32_done_count", 32'(n_done32), 32'd1);
    chk("stop32_other_quiet", 32'(n_done - base_done), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
